// File: rtl/exec_pkg.sv
// Shared definitions for the execute stage: alu_op codes, control-word layout,
// FSM state codes and flag bit positions.
package exec_pkg;
  localparam int DATA_W = 16;

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_MOV  = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_SUB  = 4'd3;
  localparam logic [3:0] OP_AND  = 4'd4;
  localparam logic [3:0] OP_OR   = 4'd5;
  localparam logic [3:0] OP_NOT  = 4'd6;
  localparam logic [3:0] OP_INC  = 4'd7;
  localparam logic [3:0] OP_DEC  = 4'd8;
  localparam logic [3:0] OP_SHL  = 4'd9;
  localparam logic [3:0] OP_SHR  = 4'd10;
  localparam logic [3:0] OP_MUL  = 4'd11;
  localparam logic [3:0] OP_SETC = 4'd12;
  localparam logic [3:0] OP_CLRC = 4'd13;

  localparam int CTRL_USE_IMM   = 4;
  localparam int CTRL_REG_WRITE = 5;
  localparam int CTRL_MEM_READ  = 6;
  localparam int CTRL_MEM_WRITE = 7;

  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_C = 2;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_MUL  = 1'b1;
endpackage

// File: rtl/exec_if.sv
// Decode->execute bundle and execute->memory result bundle as one interface.
interface exec_if;
  import exec_pkg::*;

  // A bundle transfers on a rising edge where in_valid && !stall && !flush; decode
  // holds its bundle while stall is high. out_valid pulses for one cycle per
  // completed bundle and is never back-pressured.
  logic              in_valid;
  logic [DATA_W-1:0] Imm_value_execute;
  logic [4:0]        shmnt_execute;
  logic [DATA_W-1:0] Rs_data_execute;
  logic [DATA_W-1:0] Rd_data_execute;
  logic [2:0]        Rd_execute;
  logic [7:0]        control_signals_execute;
  logic              flush;
  logic              stall;
  logic [DATA_W-1:0] result_mem;
  logic [DATA_W-1:0] store_data_mem;
  logic [2:0]        Rd_mem;
  logic [2:0]        ctrl_mem;
  logic              out_valid;
  logic [2:0]        flags;
  logic [0:0]        state_dbg;

  modport master (
    output in_valid, Imm_value_execute, shmnt_execute, Rs_data_execute,
           Rd_data_execute, Rd_execute, control_signals_execute, flush,
    input  stall, result_mem, store_data_mem, Rd_mem, ctrl_mem, out_valid,
           flags, state_dbg
  );

  modport slave (
    input  in_valid, Imm_value_execute, shmnt_execute, Rs_data_execute,
           Rd_data_execute, Rd_execute, control_signals_execute, flush,
    output stall, result_mem, store_data_mem, Rd_mem, ctrl_mem, out_valid,
           flags, state_dbg
  );
endinterface

// File: rtl/exec_mul_seq.sv
// Sequential shift-add multiplier; one partial product per clock, owns the
// IDLE/MUL state of the execute stage.
module exec_mul_seq
  import exec_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int MUL_CYCLES = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [0:0]         state,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product_next
);
  localparam int CNT_W = $clog2(MUL_CYCLES);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(MUL_CYCLES - 1);

  logic [CNT_W-1:0]   count;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;

  assign busy = (state == ST_MUL);
  assign done = busy && (count == LAST);
  // Final product is presented combinationally so the stage registers it on the last iteration edge.
  assign product_next = acc + (mplier[0] ? mcand : '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      count  <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else if (abort) begin
      state <= ST_IDLE;
      count <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state  <= ST_MUL;
            count  <= '0;
            acc    <= '0;
            mcand  <= {{WIDTH{1'b0}}, a};
            mplier <= b;
          end
        end
        default: begin
          acc    <= product_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          count  <= count + CNT_W'(1);
          if (count == LAST) state <= ST_IDLE;
        end
      endcase
    end
  end
endmodule

// File: rtl/exec_stage.sv
// Execute stage: combinational ALU and flag update with a registered result
// bundle; MUL is delegated to exec_mul_seq and stalls decode while it runs.
module exec_stage
  import exec_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int MUL_CYCLES = 16
) (
  input logic   clk,
  input logic   rst_n,
  exec_if.slave bus
);
  logic [3:0]         op;
  logic [WIDTH-1:0]   op_a;
  logic [WIDTH-1:0]   op_b;
  logic               accept;
  logic               mul_busy;
  logic               mul_done;
  logic [0:0]         mul_state;
  logic [2*WIDTH-1:0] mul_prod;
  logic [2*WIDTH-1:0] shl_wide;
  logic [2*WIDTH-1:0] shr_wide;
  logic               sh_zero;
  logic               sh_over;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_c;
  logic               upd_zn;
  logic [WIDTH-1:0]   result_q;
  logic [WIDTH-1:0]   store_q;
  logic [2:0]         rd_q;
  logic [2:0]         ctrl_q;
  logic [2:0]         flags_q;
  logic               valid_q;
  logic [WIDTH-1:0]   pend_store;
  logic [2:0]         pend_rd;
  logic [2:0]         pend_ctrl;
  logic [2:0]         ctrl_in;

  assign op      = bus.control_signals_execute[3:0];
  assign op_a    = bus.Rd_data_execute;
  assign op_b    = bus.control_signals_execute[CTRL_USE_IMM] ? bus.Imm_value_execute
                                                             : bus.Rs_data_execute;
  assign ctrl_in = {bus.control_signals_execute[CTRL_MEM_WRITE],
                    bus.control_signals_execute[CTRL_MEM_READ],
                    bus.control_signals_execute[CTRL_REG_WRITE]};
  assign accept  = bus.in_valid && !mul_busy && !bus.flush;

  exec_mul_seq #(.WIDTH(WIDTH), .MUL_CYCLES(MUL_CYCLES)) u_mul (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (accept && (op == OP_MUL)),
    .abort        (bus.flush),
    .a            (op_a),
    .b            (op_b),
    .state        (mul_state),
    .busy         (mul_busy),
    .done         (mul_done),
    .product_next (mul_prod)
  );

  // Carry for shifts is the bit just beyond the kept window of the widened operand.
  assign shl_wide = {{WIDTH{1'b0}}, op_a} << bus.shmnt_execute;
  assign shr_wide = {op_a, {WIDTH{1'b0}}} >> bus.shmnt_execute;
  assign sh_zero  = (bus.shmnt_execute == 5'd0);
  assign sh_over  = (bus.shmnt_execute > 5'd16);

  always_comb begin
    alu_res = '0;
    alu_c   = flags_q[FLAG_C];
    upd_zn  = 1'b0;
    case (op)
      OP_MOV: alu_res = op_b;
      OP_ADD: begin {alu_c, alu_res} = {1'b0, op_a} + {1'b0, op_b}; upd_zn = 1'b1; end
      OP_SUB: begin {alu_c, alu_res} = {1'b0, op_a} - {1'b0, op_b}; upd_zn = 1'b1; end
      OP_AND: begin alu_res = op_a & op_b; upd_zn = 1'b1; end
      OP_OR:  begin alu_res = op_a | op_b; upd_zn = 1'b1; end
      OP_NOT: begin alu_res = ~op_a; upd_zn = 1'b1; end
      OP_INC: begin {alu_c, alu_res} = {1'b0, op_a} + (WIDTH+1)'(1); upd_zn = 1'b1; end
      OP_DEC: begin {alu_c, alu_res} = {1'b0, op_a} - (WIDTH+1)'(1); upd_zn = 1'b1; end
      OP_SHL: begin
        upd_zn = 1'b1;
        if (sh_over) begin alu_res = '0; alu_c = 1'b0; end
        else if (sh_zero) alu_res = op_a;
        else begin alu_res = shl_wide[WIDTH-1:0]; alu_c = shl_wide[WIDTH]; end
      end
      OP_SHR: begin
        upd_zn = 1'b1;
        if (sh_over) begin alu_res = '0; alu_c = 1'b0; end
        else if (sh_zero) alu_res = op_a;
        else begin alu_res = shr_wide[2*WIDTH-1:WIDTH]; alu_c = shr_wide[WIDTH-1]; end
      end
      OP_SETC: alu_c = 1'b1;
      OP_CLRC: alu_c = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q   <= '0;
      store_q    <= '0;
      rd_q       <= '0;
      ctrl_q     <= '0;
      flags_q    <= '0;
      valid_q    <= 1'b0;
      pend_store <= '0;
      pend_rd    <= '0;
      pend_ctrl  <= '0;
    end else if (bus.flush) begin
      valid_q <= 1'b0;
    end else if (mul_done) begin
      result_q        <= mul_prod[WIDTH-1:0];
      store_q         <= pend_store;
      rd_q            <= pend_rd;
      ctrl_q          <= pend_ctrl;
      flags_q[FLAG_Z] <= (mul_prod[WIDTH-1:0] == '0);
      flags_q[FLAG_N] <= mul_prod[WIDTH-1];
      flags_q[FLAG_C] <= |mul_prod[2*WIDTH-1:WIDTH];
      valid_q         <= 1'b1;
    end else if (accept && (op == OP_MUL)) begin
      // Bundle fields are parked until the product is ready.
      pend_store <= op_a;
      pend_rd    <= bus.Rd_execute;
      pend_ctrl  <= ctrl_in;
      valid_q    <= 1'b0;
    end else if (accept) begin
      result_q        <= alu_res;
      store_q         <= op_a;
      rd_q            <= bus.Rd_execute;
      ctrl_q          <= ctrl_in;
      flags_q[FLAG_C] <= alu_c;
      if (upd_zn) begin
        flags_q[FLAG_Z] <= (alu_res == '0);
        flags_q[FLAG_N] <= alu_res[WIDTH-1];
      end
      valid_q <= 1'b1;
    end else begin
      valid_q <= 1'b0;
    end
  end

  assign bus.stall          = mul_busy;
  assign bus.result_mem     = result_q;
  assign bus.store_data_mem = store_q;
  assign bus.Rd_mem         = rd_q;
  assign bus.ctrl_mem       = ctrl_q;
  assign bus.flags          = flags_q;
  assign bus.out_valid      = valid_q;
  assign bus.state_dbg      = mul_state;
endmodule
